// File: rtl/axil_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_pkg
// Purpose  : Shared types and constants for the AXI4-Lite register bank:
//            response codes, write/read FSM state encodings and the word
//            offsets of the optional interrupt register pair (relative to
//            NUM_REGS).
// Revision : 1.0 - initial release
// ============================================================================
package axil_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_HAVE_A = 2'd1,
      WR_HAVE_D = 2'd2,
      WR_RESP   = 2'd3
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   // Interrupt registers sit directly above the last regular register.
   localparam int IRQ_STAT_OFS = 0;
   localparam int IRQ_MASK_OFS = 1;
   localparam int IRQ_W        = 8;

endpackage
`default_nettype wire

// File: rtl/axil_regbank_irq.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_irq
// Purpose  : Interrupt status/mask pair for the register bank.
//            IRQ_STAT bits are sticky on the level of i_src and cleared by
//            writing 1; a source that is high in the clearing cycle keeps
//            its bit set. IRQ_MASK is a plain RW register. o_irq is the
//            registered OR of the unmasked status bits.
// Ports    : i_clk, i_rst_n (async, active low)
//            i_src      - interrupt source levels
//            i_stat_we  - write-1-to-clear strobe for IRQ_STAT
//            i_mask_we  - write strobe for IRQ_MASK
//            i_wdata    - write data (low byte of the bus word)
//            o_stat, o_mask - register read-back
//            o_irq      - interrupt output
// Revision : 1.0 - initial release
// ============================================================================
module axil_regbank_irq
   import axil_regbank_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [IRQ_W-1:0] i_src,
   input  logic             i_stat_we,
   input  logic             i_mask_we,
   input  logic [IRQ_W-1:0] i_wdata,
   output logic [IRQ_W-1:0] o_stat,
   output logic [IRQ_W-1:0] o_mask,
   output logic             o_irq
);

   logic [IRQ_W-1:0] r_stat;
   logic [IRQ_W-1:0] r_mask;
   logic             r_irq;
   logic [IRQ_W-1:0] w_clr;

   assign w_clr = i_stat_we ? i_wdata : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat <= '0;
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         // OR-ing the source in after the clear lets a set win over a clear.
         r_stat <= (r_stat & ~w_clr) | i_src;
         if (i_mask_we) begin
            r_mask <= i_wdata;
         end
         r_irq <= |(r_stat & r_mask);
      end
   end

   assign o_stat = r_stat;
   assign o_mask = r_mask;
   assign o_irq  = r_irq;

endmodule
`default_nettype wire

// File: rtl/axil_regbank.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank
// Purpose  : AXI4-Lite slave register bank. NUM_REGS word registers; the
//            top NUM_RO indices are read-only views of status_in, the rest
//            are RW with byte strobes and a per-register write pulse.
//            Independent write (4-state) and read (2-state) FSMs.
// Ports    : S_AXI_*      - AXI4-Lite slave (clock, async active-low reset)
//            reg_out      - flat image of the RW registers (index 0 at LSB)
//            reg_wr_pulse - one-cycle strobe per committed RW write
//            status_in    - RO register sources (first RO index at LSB)
//            irq_src/irq  - only with AXIL_REGBANK_IRQ_EN
// Config   : `define AXIL_REGBANK_IRQ_EN adds IRQ_STAT (index NUM_REGS) and
//            IRQ_MASK (index NUM_REGS+1); without it those indices SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axil_regbank
   import axil_regbank_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_REGS           = 8,
   parameter int NUM_RO             = 2
) (
   input  logic                                          S_AXI_ACLK,
   input  logic                                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
   input  logic [2:0]                                    S_AXI_AWPROT,
   input  logic                                          S_AXI_AWVALID,
   output logic                                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
   input  logic                                          S_AXI_WVALID,
   output logic                                          S_AXI_WREADY,
   output logic [1:0]                                    S_AXI_BRESP,
   output logic                                          S_AXI_BVALID,
   input  logic                                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
   input  logic [2:0]                                    S_AXI_ARPROT,
   input  logic                                          S_AXI_ARVALID,
   output logic                                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
   output logic [1:0]                                    S_AXI_RRESP,
   output logic                                          S_AXI_RVALID,
   input  logic                                          S_AXI_RREADY,
   output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-NUM_RO-1:0]                    reg_wr_pulse,
`ifdef AXIL_REGBANK_IRQ_EN
   input  logic [7:0]                                    irq_src,
   output logic                                          irq,
`endif
   input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]          status_in
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int SW     = DW / 8;
   localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
   localparam int NUM_RW = NUM_REGS - NUM_RO;

   wr_state_t        r_wr_st, w_wr_nxt;
   rd_state_t        r_rd_st, w_rd_nxt;
   logic             r_ready_en;
   logic [IDX_W-1:0] r_aw_idx;
   logic [DW-1:0]    r_wdata;
   logic [SW-1:0]    r_wstrb;
   logic [1:0]       r_bresp;
   logic [DW-1:0]    r_rdata;
   logic [1:0]       r_rresp;
   logic [DW-1:0]    r_regs [NUM_RW];
   logic [NUM_RW-1:0] r_wr_pulse;

   logic             w_awready, w_wready, w_arready;
   logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
   logic [DW-1:0]    w_wr_data, w_rd_data;
   logic [SW-1:0]    w_wr_strb;
   logic [1:0]       w_wr_resp, w_rd_resp;
   logic             w_unused;

   // Address LSBs and PROT carry no meaning for this block.
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // READY lines stay low until the first clock edge after reset release.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------
   always_comb begin
      w_wr_nxt  = r_wr_st;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      case (r_wr_st)
         WR_IDLE: begin
            w_awready = r_ready_en;
            w_wready  = r_ready_en;
         end
         WR_HAVE_A: w_wready  = 1'b1;
         WR_HAVE_D: w_awready = 1'b1;
         default: ;
      endcase
      w_aw_hs = S_AXI_AWVALID & w_awready;
      w_w_hs  = S_AXI_WVALID & w_wready;
      case (r_wr_st)
         WR_IDLE: begin
            if (w_aw_hs && w_w_hs) w_wr_nxt = WR_RESP;
            else if (w_aw_hs)      w_wr_nxt = WR_HAVE_A;
            else if (w_w_hs)       w_wr_nxt = WR_HAVE_D;
         end
         WR_HAVE_A: if (w_w_hs)  w_wr_nxt = WR_RESP;
         WR_HAVE_D: if (w_aw_hs) w_wr_nxt = WR_RESP;
         WR_RESP:   if (S_AXI_BREADY) w_wr_nxt = WR_IDLE;
         default:   w_wr_nxt = WR_IDLE;
      endcase
   end

   // The write commits on the edge that completes the second handshake.
   assign w_commit  = (r_wr_st != WR_RESP) && (w_wr_nxt == WR_RESP);
   assign w_wr_idx  = (r_wr_st == WR_HAVE_A) ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_wr_data = (r_wr_st == WR_HAVE_D) ? r_wdata  : S_AXI_WDATA;
   assign w_wr_strb = (r_wr_st == WR_HAVE_D) ? r_wstrb  : S_AXI_WSTRB;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_wr_st  <= WR_IDLE;
         r_aw_idx <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bresp  <= RESP_OKAY;
      end else begin
         r_wr_st <= w_wr_nxt;
         if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
         if (w_commit) r_bresp <= w_wr_resp;
      end
   end

   // RW register file and write pulses
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_RW; i++) r_regs[i] <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         for (int i = 0; i < NUM_RW; i++) begin
            if (w_commit && (w_wr_idx == IDX_W'(i))) begin
               r_wr_pulse[i] <= 1'b1;
               for (int b = 0; b < SW; b++) begin
                  if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional interrupt registers
   // ------------------------------------------------------------------
`ifdef AXIL_REGBANK_IRQ_EN
   localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(NUM_REGS + IRQ_STAT_OFS);
   localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(NUM_REGS + IRQ_MASK_OFS);

   logic [IRQ_W-1:0] w_irq_stat, w_irq_mask;
   logic             w_stat_we, w_mask_we;

   // Only byte lane 0 holds implemented bits.
   assign w_stat_we = w_commit && (w_wr_idx == IDX_STAT) && w_wr_strb[0];
   assign w_mask_we = w_commit && (w_wr_idx == IDX_MASK) && w_wr_strb[0];

   axil_regbank_irq u_irq (
      .i_clk     (S_AXI_ACLK),
      .i_rst_n   (S_AXI_ARESETN),
      .i_src     (irq_src),
      .i_stat_we (w_stat_we),
      .i_mask_we (w_mask_we),
      .i_wdata   (w_wr_data[IRQ_W-1:0]),
      .o_stat    (w_irq_stat),
      .o_mask    (w_irq_mask),
      .o_irq     (irq)
   );
`endif

   always_comb begin
      w_wr_resp = RESP_SLVERR;
      if (w_wr_idx < IDX_W'(NUM_RW)) w_wr_resp = RESP_OKAY;
`ifdef AXIL_REGBANK_IRQ_EN
      if ((w_wr_idx == IDX_STAT) || (w_wr_idx == IDX_MASK)) w_wr_resp = RESP_OKAY;
`endif
   end

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   assign w_rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_arready = (r_rd_st == RD_IDLE) && r_ready_en;
   assign w_ar_hs   = S_AXI_ARVALID && w_arready;

   always_comb begin
      w_rd_nxt = r_rd_st;
      case (r_rd_st)
         RD_IDLE: if (w_ar_hs) w_rd_nxt = RD_RESP;
         RD_RESP: if (S_AXI_RREADY) w_rd_nxt = RD_IDLE;
         default: w_rd_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
         if (w_rd_idx == IDX_W'(i)) begin
            w_rd_data = r_regs[i];
            w_rd_resp = RESP_OKAY;
         end
      end
      for (int k = 0; k < NUM_RO; k++) begin
         if (w_rd_idx == IDX_W'(NUM_RW + k)) begin
            w_rd_data = status_in[k*DW +: DW];
            w_rd_resp = RESP_OKAY;
         end
      end
`ifdef AXIL_REGBANK_IRQ_EN
      if (w_rd_idx == IDX_STAT) begin
         w_rd_data = DW'(w_irq_stat);
         w_rd_resp = RESP_OKAY;
      end
      if (w_rd_idx == IDX_MASK) begin
         w_rd_data = DW'(w_irq_mask);
         w_rd_resp = RESP_OKAY;
      end
`endif
   end

   // Read data is captured at the AR handshake, so a same-edge write is
   // not yet visible.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rd_st <= RD_IDLE;
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else begin
         r_rd_st <= w_rd_nxt;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = (r_wr_st == WR_RESP);
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RVALID  = (r_rd_st == RD_RESP);
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign reg_wr_pulse  = r_wr_pulse;

   for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
      assign reg_out[g*DW +: DW] = r_regs[g];
   end

endmodule
`default_nettype wire
